// File: rtl/ps2_cmd_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start bit,
// shifts out cmd/odd-parity/stop on device clock falls and checks the device ACK.
module ps2_cmd_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT      = 750000,
  parameter int XFER_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_AB  = (CLK_INHIBIT_CYCLES > START_TIMEOUT) ? CLK_INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       frame_q, frame_d;   // {stop, parity, cmd[7:0]}, sent LSB first
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    frame_d  = frame_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_ONE;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = cnt_q;
        dat_oe_d = 1'b0;
        if (send) begin
          frame_d = {1'b1, ~^cmd, cmd};
          idx_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        dat_oe_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      S_REQ: begin
        // Timeout is tested first so a coincident fall loses.
        if (cnt_q == START_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (fall) begin
          cnt_d    = '0;
          dat_oe_d = ~frame_q[0];
          idx_d    = 4'd1;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == XFER_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (fall) begin
          dat_oe_d = ~frame_q[idx_q];
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd9) state_d = S_ACK;
        end
      end

      S_ACK: begin
        dat_oe_d = 1'b0;
        if (cnt_q == XFER_LAST) begin
          cnt_d   = '0;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          if (dat_sync_q) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        cnt_d    = cnt_q;
        dat_oe_d = 1'b0;
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d    = '0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      // NOTE: synchronizers reset to the idle-bus level so no false fall follows reset.
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign ps2_clk_oe = (state_q == S_INHIBIT);
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Directed bench for ps2_cmd_tx with a PS/2 device model on an open-drain bus.
// Timing parameters are scaled down so every scenario runs in a few thousand cycles.
module tb_ps2_cmd_tx;

  localparam int INH  = 50;
  localparam int ST   = 600;
  localparam int XT   = 1000;
  localparam int HALF = 20;   // device clock half-period in system cycles
  localparam int DLY  = 30;   // device response delay after clock release

  logic       CLOCK_50;
  logic       reset;
  logic       send;
  logic [7:0] cmd;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, error;
  logic       dev_clk_low, dev_dat_low;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_cmd_tx #(
    .CLK_INHIBIT_CYCLES(INH),
    .START_TIMEOUT     (ST),
    .XFER_TIMEOUT      (XT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .send      (send),
    .cmd       (cmd),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Issues send at the current negedge and plays the device side of the frame.
  // abort_at/stall_at (rise number, 0 = off) cut the transfer short.
  task automatic xfer(input logic [7:0] c, input bit ack_low, input bit inject,
                      input int abort_at, input int stall_at,
                      output logic start_bit, output logic [9:0] bits,
                      output int inh_cyc, output bit inh_dat_ok);
    bits = '0;
    send = 1'b1;
    cmd  = c;
    @(negedge CLOCK_50);
    send       = 1'b0;
    inh_cyc    = 0;
    inh_dat_ok = 1'b1;
    while (ps2_clk_oe && inh_cyc < 10 * INH) begin
      inh_cyc++;
      if (ps2_dat_oe) inh_dat_ok = 1'b0;
      send = inject && (inh_cyc == 10);
      if (inject) cmd = 8'h00;
      @(negedge CLOCK_50);
    end
    send      = 1'b0;
    start_bit = ps2_dat_in;
    wait_cyc(DLY);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      wait_cyc(HALF);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_dat_in;
      if (i == 11) dev_dat_low = 1'b0;
      if (i == abort_at) begin
        check("abort_pre_dat_oe", ps2_dat_oe, 1);
        reset = 1'b1;
        wait_cyc(1);
        return;
      end
      if (i == stall_at) return;
      if (inject && i == 5) begin
        send = 1'b1;
        cmd  = 8'h00;
        wait_cyc(1);
        send = 1'b0;
        wait_cyc(HALF - 1);
      end else if (i == 10) begin
        wait_cyc(5);
        dev_dat_low = ack_low;
        wait_cyc(HALF - 5);
      end else begin
        wait_cyc(HALF);
      end
    end
    wait_cyc(10);
  endtask

  logic       sb;
  logic [9:0] fr;
  int         ic, d0, e0, cyc;
  bit         idok;

  initial begin
    reset       = 1'b1;
    send        = 1'b0;
    cmd         = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    wait_cyc(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_busy",   busy,       0);
    check("rst_done",   done,       0);
    check("rst_error",  error,      0);
    reset = 1'b0;
    wait_cyc(2);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hED, 1'b1, 1'b0, 0, 0, sb, fr, ic, idok);
    check("ed_inhibit_cycles", ic,   INH);
    check("ed_inhibit_dat_oe", idok, 1);
    check("ed_start_bit",      sb,   0);
    check("ed_frame",          fr,   10'h3ED);
    check("ed_done_pulses",    done_cnt - d0, 1);
    check("ed_error_pulses",   err_cnt - e0,  0);
    check("ed_busy_after",     busy, 0);
    check("ed_dat_released",   ps2_dat_oe, 0);

    // 0xF4: parity 0
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hF4, 1'b1, 1'b0, 0, 0, sb, fr, ic, idok);
    check("f4_start_bit",    sb, 0);
    check("f4_frame",        fr, 10'h2F4);
    check("f4_parity",       fr[8], 0);
    check("f4_done_pulses",  done_cnt - d0, 1);
    check("f4_error_pulses", err_cnt - e0,  0);
    check("f4_busy_after",   busy, 0);

    // send=1 with cmd=0x00 during inhibit and mid-data must not disturb 0xED
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hED, 1'b1, 1'b1, 0, 0, sb, fr, ic, idok);
    check("inj_inhibit_cycles", ic, INH);
    check("inj_frame",          fr, 10'h3ED);
    check("inj_done_pulses",    done_cnt - d0, 1);
    check("inj_error_pulses",   err_cnt - e0,  0);

    // device leaves DAT high at the ACK fall
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hF4, 1'b0, 1'b0, 0, 0, sb, fr, ic, idok);
    check("nack_frame",        fr, 10'h2F4);
    check("nack_error_pulses", err_cnt - e0,  1);
    check("nack_done_pulses",  done_cnt - d0, 0);
    check("nack_busy_after",   busy, 0);

    // device never clocks: error INH+ST cycles after acceptance
    d0 = done_cnt; e0 = err_cnt;
    send = 1'b1;
    cmd  = 8'h55;
    @(negedge CLOCK_50);
    send = 1'b0;
    cyc  = 0;
    while (!error && cyc < INH + ST + 100) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check("sto_latency_in_window", (cyc >= INH + ST - 3) && (cyc <= INH + ST + 3), 1);
    @(negedge CLOCK_50);
    check("sto_error_one_cycle", error,      0);
    check("sto_clk_released",    ps2_clk_oe, 0);
    check("sto_dat_released",    ps2_dat_oe, 0);
    check("sto_busy_after",      busy,       0);
    check("sto_error_pulses",    err_cnt - e0,  1);
    check("sto_done_pulses",     done_cnt - d0, 0);
    wait_cyc(5);

    // device stops after three clocks: transfer timeout
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hED, 1'b1, 1'b0, 0, 3, sb, fr, ic, idok);
    cyc = 0;
    while (!error && cyc < 2 * XT) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check("xto_error_seen", error, 1);
    @(negedge CLOCK_50);
    check("xto_dat_released", ps2_dat_oe, 0);
    check("xto_busy_after",   busy,       0);
    check("xto_error_pulses", err_cnt - e0,  1);
    check("xto_done_pulses",  done_cnt - d0, 0);
    wait_cyc(5);

    // reset after the 4th data bit, then 0xFF sent on the first post-reset cycle
    d0 = done_cnt; e0 = err_cnt;
    xfer(8'hA0, 1'b1, 1'b0, 4, 0, sb, fr, ic, idok);
    check("abort_clk_oe",  ps2_clk_oe, 0);
    check("abort_dat_oe",  ps2_dat_oe, 0);
    check("abort_busy",    busy,       0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_err",  err_cnt - e0,  0);
    reset = 1'b0;
    xfer(8'hFF, 1'b1, 1'b0, 0, 0, sb, fr, ic, idok);
    check("ff_inhibit_cycles", ic, INH);
    check("ff_start_bit",      sb, 0);
    check("ff_frame",          fr, 10'h3FF);
    check("ff_done_pulses",    done_cnt - d0, 1);
    check("ff_error_pulses",   err_cnt - e0,  0);

    check("done_error_never_together", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_tx.md
PS2_CMD_TX -- requirements
Module: ps2_cmd_tx

Interface
REQ-001 Parameter CLK_INHIBIT_CYCLES, default 5000, sets PS2 clock hold-low time (100 us at 50 MHz).
REQ-002 Parameter START_TIMEOUT, default 750000, sets the maximum wait for the first device clock fall (15 ms).
REQ-003 Parameter XFER_TIMEOUT, default 100000, sets the maximum time from first fall to ACK (2 ms).
REQ-004 Port CLOCK_50, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port send, input, 1 bit: one-cycle command request.
REQ-007 Port cmd, input, 8 bits: command byte, sampled in the cycle send is accepted.
REQ-008 Port ps2_clk_in, input, 1 bit: raw PS2_CLK pin level.
REQ-009 Port ps2_dat_in, input, 1 bit: raw PS2_DAT pin level.
REQ-010 Port ps2_clk_oe, output, 1 bit: 1 drives PS2_CLK low; 0 releases it (high-Z).
REQ-011 Port ps2_dat_oe, output, 1 bit: 1 drives PS2_DAT low; 0 releases it (high-Z).
REQ-012 Port busy, output, 1 bit: high whenever the FSM is not IDLE; the receiver ignores the bus while it is high.
REQ-013 Port done, output, 1 bit: one-cycle pulse on a successful, ACKed transfer.
REQ-014 Port error, output, 1 bit: one-cycle pulse on a timeout or NACK.

Function
REQ-015 ps2_clk_in and ps2_dat_in SHALL each pass through a 2-FF synchronizer; a falling edge (fall) is the previous synced value 1 with the current synced value 0.
REQ-016 The FSM SHALL have states IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
REQ-017 IDLE: send=1 latches the frame {stop=1, parity, cmd[7:0]}, clears the counters and goes to INHIBIT; send is ignored in every other state.
REQ-018 Parity SHALL be odd: parity = ~^cmd.
REQ-019 INHIBIT: ps2_clk_oe=1 and ps2_dat_oe=0 for exactly CLK_INHIBIT_CYCLES cycles, then go to REQ.
REQ-020 REQ: ps2_clk_oe=0 and ps2_dat_oe=1 (start bit); this entry resets the timeout counter.
REQ-021 REQ: on the first fall, drive ps2_dat_oe = ~bit0 from the next cycle, set bit index=1 and go to DATA.
REQ-022 REQ: if no fall occurs within START_TIMEOUT cycles, go to IDLE and pulse error.
REQ-023 DATA: each fall drives ps2_dat_oe = ~frame[index] from the next cycle and increments index; frame order is cmd[0..7], parity, stop.
REQ-024 DATA: the stop bit drives ps2_dat_oe=0 (released); after placing it, go to ACK.
REQ-025 ACK: on the next fall, sample synced data; 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to IDLE and pulse error.
REQ-026 WAIT_IDLE: when both synced lines are 1, go to IDLE and pulse done.
REQ-027 A transfer timeout counter runs from the first fall; if it reaches XFER_TIMEOUT before the ACK sample, go to IDLE, release both lines the next cycle, and pulse error.
REQ-028 Exactly one of done/error SHALL pulse per accepted command; they never pulse together.
REQ-029 ps2_clk_oe SHALL be 1 only in INHIBIT; ps2_dat_oe SHALL be 0 in IDLE, INHIBIT, ACK and WAIT_IDLE.
REQ-030 A fall that coincides with a timeout expiry SHALL resolve as the timeout.
REQ-031 Timeout and inhibit counters SHALL be wide enough for the parameters without wrapping (20 bits for the defaults).

Reset
REQ-032 reset=1 SHALL give, at the next clock edge: state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, counters=0, synchronizers=1.
REQ-033 Reset mid-transfer SHALL release both lines by the next edge with no done/error pulse, and a send on the first post-reset cycle SHALL be accepted.

Verification
REQ-034 The bench SHALL cover: send cmd=0xED with a device model clocking at 12 kHz and ACKing -> clk held low 5000 cycles, start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released, done pulses once.
REQ-035 The bench SHALL cover: cmd=0xF4 -> parity bit 0, done pulse, busy low afterwards.
REQ-036 The bench SHALL cover: device never clocks -> error pulses 5000+750000 cycles (±3) after send; lines released.
REQ-037 The bench SHALL cover: device leaves DAT high at the ACK fall -> error pulse, no done.
REQ-038 The bench SHALL cover: send pulsed during busy with cmd=0x00 -> ignored; the bits on the wire remain those of the first command.
REQ-039 The bench SHALL cover: reset asserted after the 4th data bit -> both oe=0 at the next edge, no pulses, and a new send=0xFF completes with parity 1.
